// File: rtl/fir_coe_pkg.sv
// Shared definitions for the FIR coefficient path.
// Loader state encoding and the stored-word count helper.
package fir_coe_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        BURST = 2'd1,
        APPLY = 2'd2
    } coe_ld_state_e;

    // Words per coefficient set; a symmetric filter stores only half.
    function automatic int coe_taps_true(input int taps, input int sym);
        return (sym != 0) ? (taps + taps % 2) / 2 : taps;
    endfunction

endpackage

// File: rtl/fir_coe_loader.sv
// Host-side coefficient loader: collects one set, replays it
// as a contiguous reload burst, then issues the select pulse.
module fir_coe_loader
    import fir_coe_pkg::*;
#(
    parameter int COE_LOCAL_NUM = 2,
    parameter int COE_SEL_WIDTH = 2,
    parameter int COE_WIDTH     = 16,
    parameter int COE_TAPS      = 3,
    parameter int COE_SYMMETRY  = 0,
    parameter int AUTO_APPLY    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_coe_vld_i,
    output logic                     s_coe_rdy_o,
    input  logic [COE_WIDTH-1:0]     s_coe_data_i,
    input  logic                     abort_i,
    input  logic                     sel_req_vld_i,
    output logic                     sel_req_rdy_o,
    input  logic [COE_SEL_WIDTH-1:0] sel_req_index_i,
    output logic                     coe_reload_vld_o,
    output logic [COE_WIDTH-1:0]     coe_reload_data_o,
    output logic                     coe_sel_vld_o,
    output logic [COE_SEL_WIDTH-1:0] coe_sel_index_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     sel_err_o
);

    localparam int N  = coe_taps_true(COE_TAPS, COE_SYMMETRY);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [COE_SEL_WIDTH-1:0] SEL_RELOAD =
        COE_SEL_WIDTH'(COE_LOCAL_NUM);

    coe_ld_state_e        state;
    logic [CW-1:0]        wcnt;
    logic [CW-1:0]        rcnt;
    logic [CW-1:0]        rcnt_nxt;
    logic [COE_WIDTH-1:0] coe_buf [N];
    logic [COE_WIDTH-1:0] first_word;

    assign s_coe_rdy_o   = (state == FILL);
    assign sel_req_rdy_o = (state == FILL);
    assign busy_o        = (state != FILL);
    assign rcnt_nxt      = rcnt + 1'b1;

    // Word 0 of the burst bypasses the buffer when it arrives on the final handshake.
    always_comb begin
        first_word = coe_buf[0];
        if (wcnt == '0) begin
            first_word = s_coe_data_i;
        end
    end

    // Fill / burst / apply sequencing with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= FILL;
            wcnt              <= '0;
            rcnt              <= '0;
            for (int i = 0; i < N; i++) begin
                coe_buf[i] <= '0;
            end
            coe_reload_vld_o  <= 1'b0;
            coe_reload_data_o <= '0;
            coe_sel_vld_o     <= 1'b0;
            coe_sel_index_o   <= '0;
            done_o            <= 1'b0;
            sel_err_o         <= 1'b0;
        end else begin
            done_o          <= 1'b0;
            sel_err_o       <= 1'b0;
            coe_sel_vld_o   <= 1'b0;
            coe_sel_index_o <= '0;
            unique case (state)
                FILL: begin
                    if (abort_i) begin
                        wcnt <= '0;
                    end else if (s_coe_vld_i) begin
                        coe_buf[wcnt] <= s_coe_data_i;
                        if (wcnt == LAST) begin
                            state             <= BURST;
                            wcnt              <= '0;
                            rcnt              <= '0;
                            coe_reload_vld_o  <= 1'b1;
                            coe_reload_data_o <= first_word;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    if (sel_req_vld_i) begin
                        if (sel_req_index_i <= SEL_RELOAD) begin
                            coe_sel_vld_o   <= 1'b1;
                            coe_sel_index_o <= sel_req_index_i;
                        end else begin
                            sel_err_o <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (rcnt == LAST) begin
                        state             <= APPLY;
                        coe_reload_vld_o  <= 1'b0;
                        coe_reload_data_o <= '0;
                        done_o            <= 1'b1;
                        if (AUTO_APPLY != 0) begin
                            coe_sel_vld_o   <= 1'b1;
                            coe_sel_index_o <= SEL_RELOAD;
                        end
                    end else begin
                        rcnt              <= rcnt_nxt;
                        coe_reload_data_o <= coe_buf[rcnt_nxt];
                    end
                end
                APPLY: begin
                    state <= FILL;
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
